mul_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one repeated-addition multiplier unit (control path plus datapath) among N_REQ requesters.
- Accepts per-requester operand pairs and latches the winner's operands into the unit.
- Drives the unit's level-sensitive start/done handshake and returns the product to the owning requester with a one-cycle response pulse.
- Sits between client blocks and the single shared multiplier instance.

---
 rtl/mul_rr_arbiter_pkg.sv | 14 +
 rtl/mul_rr_arbiter_rr_pick.sv | 29 ++
 rtl/mul_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mul_rr_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_rr_arbiter_pkg.sv
// rtl/mul_rr_arbiter_pkg.sv - shared state encoding and default widths for mul_rr_arbiter
package mul_rr_arbiter_pkg;

    localparam int DEF_W  = 8;
    localparam int DEF_RW = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        RESP  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/mul_rr_arbiter_rr_pick.sv
// rtl/mul_rr_arbiter_rr_pick.sv - combinational round-robin picker: first set req bit at or above ptr, wrapping
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [PW-1:0] idx
);

    int c;

    // Scan from farthest to nearest so the candidate closest to ptr overwrites the rest.
    always_comb begin
        winner = '0;
        idx    = '0;
        c      = 0;
        for (int k = N - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N;
            if (req[c]) begin
                winner    = '0;
                winner[c] = 1'b1;
                idx       = PW'(c);
            end
        end
    end

endmodule

// File: rtl/mul_rr_arbiter.sv
// rtl/mul_rr_arbiter.sv - round-robin sequencer sharing one multiplier unit; MUL_ARB_WDOG_EN adds a RUN watchdog
module mul_rr_arbiter
    import mul_rr_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = DEF_W,
    parameter int RW      = DEF_RW,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [RW-1:0]      rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               unit_start,
    output logic [W-1:0]       unit_a,
    output logic [W-1:0]       unit_b,
    input  logic               unit_done,
    input  logic [RW-1:0]      unit_result
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t           state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [N_REQ-1:0] owner_oh;
    logic             wd_fire;

    rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .winner(pick_oh),
        .idx   (pick_idx)
    );

    assign owner_oh = N_REQ'(1) << owner;

`ifdef MUL_ARB_WDOG_EN
    localparam int CW = $clog2(TIMEOUT) + 1;
    logic [CW-1:0] wd_cnt;
    assign wd_fire = (wd_cnt == CW'(TIMEOUT - 1));
`else
    // Without the watchdog TIMEOUT has no effect; it stays so both builds share one parameter list.
    localparam int timeout_unused = TIMEOUT;
    assign wd_fire = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            busy       <= 1'b0;
            unit_start <= 1'b0;
            unit_a     <= '0;
            unit_b     <= '0;
`ifdef MUL_ARB_WDOG_EN
            wd_cnt     <= '0;
            rsp_err    <= 1'b0;
`endif
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
`ifdef MUL_ARB_WDOG_EN
            rsp_err   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt        <= pick_oh;
                        owner      <= pick_idx;
                        unit_a     <= a_in[int'(pick_idx)*W +: W];
                        unit_b     <= b_in[int'(pick_idx)*W +: W];
                        unit_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= RUN;
`ifdef MUL_ARB_WDOG_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                RUN: begin
`ifdef MUL_ARB_WDOG_EN
                    wd_cnt <= wd_cnt + 1'b1;
`endif
                    if (unit_done) begin
                        rsp_data  <= unit_result;
                        rsp_valid <= owner_oh;
                        state     <= RESP;
                    end else if (wd_fire) begin
                        rsp_data  <= '0;
                        rsp_valid <= owner_oh;
                        state     <= RESP;
`ifdef MUL_ARB_WDOG_EN
                        rsp_err   <= 1'b1;
`endif
                    end
                end
                RESP: begin
                    unit_start <= 1'b0;
                    ptr        <= (owner == PW'(N_REQ - 1)) ? '0 : owner + 1'b1;
                    state      <= DRAIN;
                end
                DRAIN: begin
                    // Hold off the next job until the unit has dropped done from the previous one.
                    if (!unit_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// tb/tb_mul_rr_arbiter.sv - randomized self-checking bench for mul_rr_arbiter with a repeated-addition unit model
module tb_mul_rr_arbiter;

    localparam int N       = 4;
    localparam int W       = 8;
    localparam int RW      = 16;
    localparam int TIMEOUT = 16;
`ifdef MUL_ARB_WDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;
    logic [N-1:0]   gnt, rsp_valid;
    logic [RW-1:0]  rsp_data;
    logic           rsp_err, busy, unit_start;
    logic [W-1:0]   unit_a, unit_b;
    logic           unit_done = 1'b0;
    logic [RW-1:0]  unit_result = '0;

    int n_tests = 0;
    int n_fail  = 0;

    mul_rr_arbiter #(.N_REQ(N), .W(W), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy), .unit_start(unit_start), .unit_a(unit_a), .unit_b(unit_b),
        .unit_done(unit_done), .unit_result(unit_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Unit model: one addition per cycle while start is high, done level held, optional stale tail.
    int          stale_n = 0;
    bit          hang = 1'b0;
    int          u_cnt = 0;
    int          u_hold = 0;
    logic [RW-1:0] u_acc = '0;

    always @(negedge clk) begin
        if (rst) begin
            unit_done = 1'b0; u_acc = '0; u_cnt = 0; u_hold = 0;
        end else if (unit_start) begin
            u_hold = stale_n;
            if (!unit_done && !hang) begin
                if (u_cnt < int'(unit_b)) begin
                    u_acc = u_acc + RW'(unit_a);
                    u_cnt++;
                end
                if (u_cnt >= int'(unit_b)) unit_done = 1'b1;
            end
        end else begin
            u_acc = '0; u_cnt = 0;
            if (unit_done) begin
                if (u_hold == 0) unit_done = 1'b0;
                else u_hold--;
            end
        end
        unit_result = u_acc;
    end

    // Reference model: job-level phases, pointer and grant rule straight from the behaviour description.
    typedef enum int {P_IDLE, P_JOB, P_RESP, P_DRAIN} phase_t;
    phase_t         m_phase = P_IDLE;
    int             m_ptr = 0, m_owner = 0, m_run = 0, n_rsp = 0, n_err = 0;
    int             m_a = 0, m_b = 0;
    int             last_data = 0;
    int             glog[$];
    logic [N-1:0]   req_s;
    logic [N*W-1:0] a_s, b_s;
    logic           done_s, rst_s;

    function automatic int ref_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return 0;
    endfunction

    always @(posedge clk) begin
        logic [N-1:0] exp_gnt, exp_rsp;
        bit fire, err;
        int w;
        req_s = req; a_s = a_in; b_s = b_in; done_s = unit_done; rst_s = rst;
        #1;
        if (rst_s || rst) begin
            m_phase = P_IDLE;
            m_ptr   = 0;
        end else begin
            exp_gnt = '0; exp_rsp = '0; fire = 1'b0; err = 1'b0;
            case (m_phase)
                P_IDLE: if (req_s != '0) begin
                    w = ref_pick(req_s, m_ptr);
                    exp_gnt = N'(1) << w;
                    m_owner = w;
                    m_a = int'(a_s[w*W +: W]);
                    m_b = int'(b_s[w*W +: W]);
                    m_run = 0;
                    m_phase = P_JOB;
                    glog.push_back(w);
                end
                P_JOB: begin
                    m_run++;
                    err  = WD && !done_s && (m_run == TIMEOUT);
                    fire = done_s || err;
                    if (fire) begin
                        exp_rsp = N'(1) << m_owner;
                        m_ptr = (m_owner + 1) % N;
                        m_phase = P_RESP;
                    end
                end
                P_RESP:  m_phase = P_DRAIN;
                P_DRAIN: if (!done_s) m_phase = P_IDLE;
            endcase
            check("gnt", gnt, exp_gnt);
            check("rsp_valid", rsp_valid, exp_rsp);
            if (exp_gnt != '0) begin
                check("unit_a", unit_a, m_a);
                check("unit_b", unit_b, m_b);
            end
            if (fire) begin
                check("rsp_data", rsp_data, err ? 0 : (m_a * m_b) & 16'hffff);
                check("rsp_err", rsp_err, err);
                n_rsp++;
                if (err) n_err++;
                last_data = int'(rsp_data);
            end else begin
                check("rsp_err_idle", rsp_err, 0);
            end
            check("busy", busy, m_phase != P_IDLE);
            check("unit_start", unit_start, m_phase == P_JOB || m_phase == P_RESP);
        end
    end

    task automatic set_ops(input int i, input int a, input int b);
        a_in[i*W +: W] = W'(a);
        b_in[i*W +: W] = W'(b);
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_rsp_err"}, rsp_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_unit_start"}, unit_start, 0);
        check({tag, "_unit_a"}, unit_a, 0);
        check({tag, "_unit_b"}, unit_b, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grants(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (glog.size() >= n) break;
        end
        check("grant_wait", glog.size() >= n, 1);
    endtask

    task automatic wait_rsp(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_rsp >= n) break;
        end
        check("rsp_wait", n_rsp >= n, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && m_phase == P_IDLE) break;
        end
        check("idle_wait", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench exceeded its time limit");
    end

    initial begin
        int base;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;

        set_ops(0, 5, 7);
        req = 4'b0001;
        wait_grants(1, 20);
        req = '0;
        wait_idle(200);
        check("single_owner", glog[0], 0);
        check("single_data", last_data, 35);

        do_reset();
        base = glog.size();
        for (int i = 0; i < N; i++) set_ops(i, i + 3, i + 2);
        req = 4'b1111;
        wait_grants(base + 5, 400);
        req = '0;
        wait_idle(200);
        for (int k = 0; k < 5; k++) check("fair_order", glog[base + k], k % N);
        check("fair_last_data", last_data, 3 * 2);

        do_reset();
        base = glog.size();
        set_ops(0, 9, 4); set_ops(2, 6, 6);
        req = 4'b0100;
        wait_grants(base + 1, 20);
        req = '0;
        wait_idle(200);
        req = 4'b0101;
        wait_grants(base + 3, 200);
        req = '0;
        wait_idle(200);
        check("wrap_first", glog[base + 1], 0);
        check("wrap_second", glog[base + 2], 2);

        do_reset();
        stale_n = 3;
        base = glog.size();
        set_ops(0, 13, 3); set_ops(1, 9, 11);
        req = 4'b0011;
        wait_grants(base + 2, 200);
        req = '0;
        wait_idle(200);
        stale_n = 0;
        check("stale_second", glog[base + 1], 1);
        check("stale_data", last_data, 99);

        do_reset();
        set_ops(1, 12, 10);
        req = 4'b0010;
        base = glog.size();
        wait_grants(base + 1, 20);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        base = glog.size();
        wait_grants(base + 1, 20);
        req = '0;
        wait_idle(200);
        check("midreset_owner", glog[base], 1);
        check("midreset_data", last_data, 120);

`ifdef MUL_ARB_WDOG_EN
        do_reset();
        hang = 1'b1;
        set_ops(0, 3, 3); set_ops(1, 4, 5);
        base = n_rsp;
        req = 4'b0011;
        wait_rsp(base + 1, 60);
        hang = 1'b0;
        base = glog.size();
        wait_grants(base + 1, 40);
        req = '0;
        wait_idle(200);
        check("wdog_err_count", n_err, 1);
        check("wdog_next_owner", glog[base], 1);
        check("wdog_next_data", last_data, 20);
`endif

        do_reset();
        for (int it = 0; it < 30; it++) begin
            @(negedge clk);
            req = N'($urandom);
            for (int i = 0; i < N; i++) set_ops(i, $urandom_range(0, 255), $urandom_range(0, 15));
            stale_n = $urandom_range(0, 3);
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end
        req = '0;
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
